// File: rtl/uart_pkg.sv
// Shared UART framing constants, transmit state encoding and counter sizing helper.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int unsigned FRAME_OVERHEAD = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Counter width for n states, never below one bit so single-state counters still exist.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Serialises one word per start pulse as a UART frame: start bit, LSB-first data, stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BITS_PER_WORD-1:0] word,
  output logic                     ready_c,
  output logic                     last_c,
  output logic                     tx
);

  localparam int unsigned BITS_PER_FRAME = BITS_PER_WORD + FRAME_OVERHEAD;
  localparam int unsigned PCW = cnt_width(CLOCKS_PER_PULSE);
  localparam int unsigned BCW = cnt_width(BITS_PER_FRAME);
  localparam logic [PCW-1:0] PULSE_LAST    = PCW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BCW-1:0] BIT_STOP      = BCW'(BITS_PER_FRAME - 1);
  localparam logic [BCW-1:0] BIT_LAST_DATA = BCW'(BITS_PER_WORD);

  tx_state_e                state_q, state_d;
  logic [PCW-1:0]           pulse_cnt_q, pulse_cnt_d;
  logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic                     tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= IDLE_LEVEL;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

  // Counters always describe the bit currently on the line; tx_d is the bit for the next cycle.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;

    last_c  = (state_q == SEND) && (pulse_cnt_q == PULSE_LAST) && (bit_cnt_q == BIT_STOP);
    ready_c = (state_q == IDLE) || last_c;

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (start) begin
          state_d     = SEND;
          shift_d     = word;
          tx_d        = START_BIT;
          pulse_cnt_d = '0;
          bit_cnt_d   = '0;
        end
      end
      SEND: begin
        if (pulse_cnt_q != PULSE_LAST) begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end else begin
          pulse_cnt_d = '0;
          if (bit_cnt_q == BIT_STOP) begin
            bit_cnt_d = '0;
            // A start in the final stop cycle chains the next frame with no idle gap.
            if (start) begin
              shift_d = word;
              tx_d    = START_BIT;
            end else begin
              state_d = IDLE;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q < BIT_LAST_DATA) begin
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end else begin
              tx_d = STOP_BIT;
            end
          end
        end
      end
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/axis_to_uart_tx.sv
// AXI-Stream slave that splits each beat into words and sends them LSB-word-first as UART frames.
module axis_to_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned W_IN             = 16,
  parameter int unsigned BITS_PER_WORD    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W_IN-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int unsigned WCW = cnt_width(NUM_WORDS);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_WORDS - 1);

  if ((W_IN % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("axis_to_uart_tx: W_IN (%0d) must be a multiple of BITS_PER_WORD (%0d)", W_IN, BITS_PER_WORD);
  end
  if (CLOCKS_PER_PULSE < 1) begin : g_bad_pulse
    $error("axis_to_uart_tx: CLOCKS_PER_PULSE must be at least 1");
  end

  tx_state_e                                    state_q, state_d;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]      beat_q, beat_d;
  logic [WCW-1:0]                               word_cnt_q, word_cnt_d;
  logic                                         busy_q, busy_d;

  logic                     hs_c;
  logic                     ser_start_c;
  logic [BITS_PER_WORD-1:0] ser_word_c;
  logic                     ser_ready_c;
  logic                     ser_last_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Ready depends only on registered state, so a new beat can land in the final stop cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    word_cnt_d  = word_cnt_q;
    ser_start_c = 1'b0;
    ser_word_c  = s_data[BITS_PER_WORD-1:0];

    s_ready = !rst && ser_ready_c && ((state_q == IDLE) || (word_cnt_q == WORD_LAST));
    hs_c    = s_valid && s_ready;

    unique case (state_q)
      IDLE: begin
        if (hs_c) begin
          state_d     = SEND;
          beat_d      = s_data;
          word_cnt_d  = '0;
          ser_start_c = 1'b1;
        end
      end
      SEND: begin
        if (ser_last_c) begin
          if (word_cnt_q != WORD_LAST) begin
            word_cnt_d  = word_cnt_q + 1'b1;
            ser_start_c = 1'b1;
            ser_word_c  = beat_q[word_cnt_q + 1'b1];
          end else if (hs_c) begin
            beat_d      = s_data;
            word_cnt_d  = '0;
            ser_start_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    busy_d = (state_d == SEND);
  end

  uart_tx_serializer #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (ser_start_c),
    .word   (ser_word_c),
    .ready_c(ser_ready_c),
    .last_c (ser_last_c),
    .tx     (tx)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Self-checking bench for axis_to_uart_tx: frame-level UART decoder with a beat scoreboard plus cycle checks.
`timescale 1ns/1ps
module tb_axis_to_uart_tx;

  localparam int unsigned CPP      = 4;
  localparam int unsigned W        = 16;
  localparam int unsigned BPW      = 8;
  localparam int unsigned NW       = W / BPW;
  localparam int unsigned FBITS    = BPW + 2;
  localparam int unsigned BEAT_CYC = NW * FBITS * CPP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] s_data;
  logic         s_valid, s_ready, tx, busy;
  logic [7:0]   s_data1;
  logic         s_valid1, s_ready1, tx1, busy1;

  axis_to_uart_tx #(.CLOCKS_PER_PULSE(4), .W_IN(16), .BITS_PER_WORD(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx(tx), .busy(busy)
  );

  axis_to_uart_tx #(.CLOCKS_PER_PULSE(1), .W_IN(8), .BITS_PER_WORD(8)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1),
    .s_ready(s_ready1), .tx(tx1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for cycle cyc of a beat carrying d.
  function automatic logic frame_bit(input logic [W-1:0] d, input int cyc);
    int w = cyc / int'(FBITS * CPP);
    int b = (cyc % int'(FBITS * CPP)) / int'(CPP);
    if (b == 0) return 1'b0;
    if (b == int'(FBITS) - 1) return 1'b1;
    return d[w * int'(BPW) + b - 1];
  endfunction

  // Scoreboard and line decoder; everything here is sampled on the falling edge.
  logic [W-1:0]   sb_q[$];
  int             hs_cnt = 0;
  int             rx_beats = 0;
  bit             rx_act = 1'b0;
  int             rx_c = 0;
  int             rx_w = 0;
  int             rx_b = 0;
  logic [BPW-1:0] rx_byte = '0;
  logic [W-1:0]   rx_beat = '0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      rx_act = 1'b0;
      rx_w   = 0;
    end else begin
      if (s_valid && s_ready) begin
        sb_q.push_back(s_data);
        hs_cnt++;
      end
      if (!rx_act && tx == 1'b0) begin
        rx_act = 1'b1;
        rx_c   = 0;
      end
      if (rx_act) begin
        if (rx_c % int'(CPP) == int'(CPP / 2)) begin
          rx_b = rx_c / int'(CPP);
          if (rx_b == 0) check_eq("rx_start_bit", tx, 1'b0);
          else if (rx_b <= int'(BPW)) rx_byte[rx_b-1] = tx;
          else check_eq("rx_stop_bit", tx, 1'b1);
        end
        if (rx_c == int'(FBITS * CPP) - 1) begin
          rx_act = 1'b0;
          rx_beat[rx_w*int'(BPW) +: BPW] = rx_byte;
          rx_w++;
          if (rx_w == int'(NW)) begin
            rx_w = 0;
            rx_beats++;
            if (sb_q.size() == 0) check_eq("rx_unexpected_beat", rx_beat, 32'hDEAD_BEEF);
            else check_eq("rx_beat", rx_beat, sb_q.pop_front());
          end
        end else begin
          rx_c++;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("hs_within_budget", ok, 1'b1);
  endtask

  // Presents d, returns just after the accepting edge with s_valid dropped.
  task automatic send_beat(input logic [W-1:0] d);
    bit ok;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = d;
    wait_ready(ok);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"}, tx, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_ready"}, s_ready, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    int          hs0, rx0, lows, gap;
    logic [9:0]  exp1;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_valid1 = 1'b0; s_data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", s_ready, 1'b0);
    check_eq("rst_tx1", tx1, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    // Single beat, bit-exact line trace.
    send_beat(16'hA53C);
    for (int i = 0; i < int'(BEAT_CYC); i++) begin
      @(negedge clk);
      check_eq("t1_tx", tx, frame_bit(16'hA53C, i));
      check_eq("t1_busy", busy, 1'b1);
      check_eq("t1_ready", s_ready, i == int'(BEAT_CYC) - 1);
    end
    @(negedge clk);
    check_idle("t1_end");

    // Back-to-back beats with s_valid held high.
    @(posedge clk); #1;
    hs0 = hs_cnt;
    s_valid = 1'b1;
    s_data  = 16'h00FF;
    wait_ready(ok);
    @(posedge clk); #1 s_data = 16'hFFFF;
    for (int i = 0; i < 2 * int'(BEAT_CYC); i++) begin
      @(negedge clk);
      check_eq("t2_busy", busy, 1'b1);
      check_eq("t2_ready", s_ready, (i % int'(BEAT_CYC)) == int'(BEAT_CYC) - 1);
      check_eq("t2_tx", tx, frame_bit((i < int'(BEAT_CYC)) ? 16'h00FF : 16'hFFFF, i % int'(BEAT_CYC)));
      if (i == int'(BEAT_CYC) - 1) begin
        @(posedge clk); #1 s_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("t2_end");
    check_eq("t2_handshakes", hs_cnt - hs0, 2);

    // Backpressure: s_data changes while the first beat is still on the line.
    @(posedge clk); #1;
    hs0 = hs_cnt;
    s_valid = 1'b1;
    s_data  = 16'h5A96;
    wait_ready(ok);
    @(posedge clk); #1;
    for (int i = 0; i < int'(BEAT_CYC); i++) begin
      @(negedge clk);
      check_eq("t3_tx_first", tx, frame_bit(16'h5A96, i));
      check_eq("t3_ready", s_ready, i == int'(BEAT_CYC) - 1);
      if (i == 19) begin
        @(posedge clk); #1 s_data = 16'h1234;
      end
      if (i == int'(BEAT_CYC) - 1) begin
        @(posedge clk); #1 s_valid = 1'b0;
      end
    end
    for (int i = 0; i < int'(BEAT_CYC); i++) begin
      @(negedge clk);
      check_eq("t3_tx_second", tx, frame_bit(16'h1234, i));
    end
    @(negedge clk);
    check_idle("t3_end");
    check_eq("t3_handshakes", hs_cnt - hs0, 2);

    // Reset in cycle 30 of a beat aborts the frame.
    send_beat(16'hC3A5);
    for (int i = 0; i < 30; i++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("t4_after_rst");
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check_eq("t4_quiet_line", lows, 0);

    // Random beats with random s_valid gaps, checked through the decoder.
    rx0 = rx_beats;
    for (int n = 0; n < 50; n++) begin
      gap = int'($urandom_range(1, 100));
      repeat (gap) @(posedge clk);
      send_beat(W'($urandom));
    end
    repeat (BEAT_CYC + 10) @(negedge clk);
    check_eq("t5_sb_empty", sb_q.size(), 0);
    check_eq("t5_beats_rx", rx_beats - rx0, 50);
    check_idle("t5_end");

    // One clock per bit, single-word beat.
    @(posedge clk); #1;
    s_valid1 = 1'b1;
    s_data1  = 8'h81;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready1) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t6_hs_within_budget", ok, 1'b1);
    @(posedge clk); #1 s_valid1 = 1'b0;
    exp1 = 10'b11_0000_0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t6_tx", tx1, exp1[i]);
      check_eq("t6_busy", busy1, 1'b1);
    end
    @(negedge clk);
    check_eq("t6_end_tx", tx1, 1'b1);
    check_eq("t6_end_busy", busy1, 1'b0);
    check_eq("t6_end_ready", s_ready1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
